// File: rtl/hls_ctrl_master_if.sv
// Handshake bundle between the ap_ctrl_hs sequencer, its command/response
// clients and one HLS kernel. The master modport is the sequencer's view.
interface hls_ctrl_master_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2
);
  // Command port (job operands)
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IN_W-1:0]  cmd_data;
  // Response port (result + status)
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic [1:0]       rsp_status;
  // Kernel block-level control and data
  logic             dut_ap_start;
  logic             dut_ap_done;
  logic             dut_ap_idle;
  logic             dut_ap_ready;
  logic [IN_W-1:0]  dut_args;
  logic [OUT_W-1:0] dut_res;
  logic             dut_res_ap_vld;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready,
    input  dut_ap_done, dut_ap_idle, dut_ap_ready, dut_res, dut_res_ap_vld,
    output cmd_ready, rsp_valid, rsp_data, rsp_status, dut_ap_start, dut_args
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready,
    output dut_ap_done, dut_ap_idle, dut_ap_ready, dut_res, dut_res_ap_vld,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status, dut_ap_start, dut_args
  );
endinterface

// File: rtl/hls_ctrl_master.sv
// Initiator side of the ap_ctrl_hs handshake: takes one job from the command
// port, pulses ap_start to the kernel, captures the ap_vld-qualified result and
// returns result + status on the response port, with a timeout guard.
module hls_ctrl_master #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2,
  parameter int TMO   = 255,
  parameter int CNT_W = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  hls_ctrl_master_if.master  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   job_count
);

  // Timer only needs to reach TMO-1: the expiry decision is taken on that cycle.
  localparam int                TMR_W    = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TMO - 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TMO   = 2'b01;
  localparam logic [1:0] ST_NOVLD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             vld_seen;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [OUT_W-1:0] rsp_data_q;
  logic [1:0]       rsp_status_q;
  logic             ap_start_q;
  logic [IN_W-1:0]  args_q;

  // ap_idle is informational only; it never steers the sequencer.
  logic unused_ap_idle;
  assign unused_ap_idle = bus.dut_ap_idle;

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_status   = rsp_status_q;
  assign bus.dut_ap_start = ap_start_q;
  assign bus.dut_args     = args_q;

  // Job sequencer: every output is a register updated alongside the state.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, regardless of statement order within the block.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      vld_seen     <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      ap_start_q   <= 1'b0;
      args_q       <= '0;
      busy         <= 1'b0;
      job_count    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            args_q      <= bus.cmd_data;
            timer       <= '0;
            vld_seen    <= 1'b0;
            cmd_ready_q <= 1'b0;
            ap_start_q  <= 1'b1;
            busy        <= 1'b1;
            state       <= S_START;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        S_START, S_WAIT: begin
          // Last strobe before (or with) ap_done wins.
          if (bus.dut_res_ap_vld) begin
            rsp_data_q <= bus.dut_res;
            vld_seen   <= 1'b1;
          end
          timer <= timer + 1'b1;
          if (bus.dut_ap_done) begin
            // Done takes priority over a coincident timer expiry.
            ap_start_q   <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= (vld_seen || bus.dut_res_ap_vld) ? ST_OK : ST_NOVLD;
            state        <= S_RESP;
          end else if (timer == TMR_LAST) begin
            ap_start_q   <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_TMO;
            state        <= S_RESP;
          end else if (state == S_START && bus.dut_ap_ready) begin
            ap_start_q <= 1'b0;
            state      <= S_WAIT;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            job_count   <= job_count + 1'b1;
            cmd_ready_q <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_ctrl_master.sv
// Self-checking bench for hls_ctrl_master: a configurable kernel model plus a
// job-level reference model (latency, ap_start width, result, status, count).
module tb_hls_ctrl_master;
  localparam int IN_W  = 3;
  localparam int OUT_W = 2;
  localparam int TMO   = 8;
  localparam int CNT_W = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  hls_ctrl_master_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  hls_ctrl_master #(.IN_W(IN_W), .OUT_W(OUT_W), .TMO(TMO), .CNT_W(CNT_W)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .bus       (bus),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] popcount(input logic [IN_W-1:0] v);
    return OUT_W'($countones(v));
  endfunction

  // ---------------- kernel model (driven on falling edges) ----------------
  // Job timeline in kernel cycles k_t: 0 is the first cycle ap_start is seen.
  int               k_ready_lat = 0;
  int               k_done_lat  = 0;
  logic [15:0]      k_vld_mask  = '0;
  logic [OUT_W-1:0] k_vals [16];
  bit               k_fa        = 1'b0;  // full_adder: result computed from args
  bit               k_stray     = 1'b0;  // random noise while no job is running
  bit               k_busy      = 1'b0;
  int               k_t         = 0;

  always @(negedge ap_clk) begin
    if (!busy) k_busy = 1'b0;
    else if (k_busy) begin
      if (k_t == k_done_lat) k_busy = 1'b0;
      else k_t++;
    end
    if (!k_busy && busy && bus.dut_ap_start) begin
      k_busy = 1'b1;
      k_t    = 0;
    end
    bus.dut_ap_idle = !k_busy;
    if (k_busy) begin
      bus.dut_ap_done  = (k_t == k_done_lat);
      bus.dut_ap_ready = (k_t == k_ready_lat) || (k_t == k_done_lat);
      if (k_fa) begin
        bus.dut_res_ap_vld = (k_t == k_done_lat);
        bus.dut_res        = popcount(bus.dut_args);
      end else begin
        bus.dut_res_ap_vld = (k_t < 16) ? k_vld_mask[k_t] : 1'b0;
        bus.dut_res        = (k_t < 16) ? k_vals[k_t] : OUT_W'($urandom);
      end
    end else if (k_stray) begin
      bus.dut_ap_done    = 1'($urandom);
      bus.dut_ap_ready   = 1'($urandom);
      bus.dut_res_ap_vld = 1'($urandom);
      bus.dut_res        = OUT_W'($urandom);
    end else begin
      bus.dut_ap_done    = 1'b0;
      bus.dut_ap_ready   = 1'b0;
      bus.dut_res_ap_vld = 1'b0;
      bus.dut_res        = '0;
    end
  end

  // ---------------- reference model state ----------------
  logic [OUT_W-1:0] model_data  = '0;  // last captured result survives across jobs
  int               model_count = 0;

  task automatic set_kernel(input int rl, input int dl, input logic [15:0] mask);
    k_ready_lat = rl;
    k_done_lat  = dl;
    k_vld_mask  = mask;
    for (int i = 0; i < 16; i++) k_vals[i] = OUT_W'($urandom);
  endtask

  // One complete job, entered and left on a falling edge with the DUT idle.
  task automatic run_job(input logic [IN_W-1:0] cmd, input int hold, input string tag);
    int               end_k, exp_lat, exp_start, wait_n, k, start_n;
    bit               any_vld, args_ok, ctrl_ok, hold_ok;
    logic [OUT_W-1:0] exp_d;
    logic [1:0]       exp_st;

    // Reference: the job window closes at done or at the last cycle before abort.
    end_k = (k_done_lat < TMO) ? k_done_lat : TMO - 1;
    exp_d = model_data;
    any_vld = 1'b0;
    if (k_fa) begin
      any_vld = 1'b1;
      exp_d   = popcount(cmd);
    end else begin
      for (int i = 0; i <= end_k; i++)
        if (k_vld_mask[i]) begin
          any_vld = 1'b1;
          exp_d   = k_vals[i];
        end
    end
    exp_st     = (k_done_lat >= TMO) ? 2'b01 : (any_vld ? 2'b00 : 2'b10);
    model_data = exp_d;
    exp_lat    = end_k + 2;
    exp_start  = ((k_ready_lat < end_k) ? k_ready_lat : end_k) + 1;

    bus.cmd_valid = 1'b1;
    bus.cmd_data  = cmd;
    wait_n = 0;
    while (bus.cmd_ready !== 1'b1 && wait_n < 20) begin
      @(negedge ap_clk);
      wait_n++;
    end
    check({tag, "/accept_wait"}, wait_n, 0);

    @(negedge ap_clk);
    bus.cmd_valid = 1'b0;
    k = 1; start_n = 0; args_ok = 1'b1; ctrl_ok = 1'b1;
    while (bus.rsp_valid !== 1'b1 && k < 40) begin
      if (bus.dut_ap_start === 1'b1) begin
        start_n++;
        if (bus.dut_args !== cmd) args_ok = 1'b0;
      end
      if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) ctrl_ok = 1'b0;
      @(negedge ap_clk);
      k++;
    end
    check({tag, "/latency"},     k, exp_lat);
    check({tag, "/start_width"}, start_n, exp_start);
    check({tag, "/args_stable"}, args_ok, 1);
    check({tag, "/busy_noready"}, ctrl_ok, 1);
    check({tag, "/rsp_data"},    bus.rsp_data, exp_d);
    check({tag, "/rsp_status"},  bus.rsp_status, exp_st);

    // Back-pressure: response must hold while a competing command is offered.
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = ~cmd;
      @(negedge ap_clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_status !== exp_st ||
          bus.cmd_ready !== 1'b0 || bus.dut_ap_start !== 1'b0) hold_ok = 1'b0;
    end
    if (hold > 0) check({tag, "/hold_stable"}, hold_ok, 1);

    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge ap_clk);
    bus.rsp_ready = 1'b0;
    model_count++;
    check({tag, "/taken"}, {bus.rsp_valid, bus.dut_ap_start, busy}, 3'b000);
    check({tag, "/job_count"}, job_count, CNT_W'(model_count));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int wait_n;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) k_vals[i] = '0;

    // Reset values
    repeat (3) @(negedge ap_clk);
    check("reset/ctrl", {busy, bus.cmd_ready, bus.rsp_valid, bus.dut_ap_start}, 4'b0000);
    check("reset/data", {bus.rsp_data, bus.rsp_status, bus.dut_args}, '0);
    check("reset/count", job_count, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("reset/ready_rises", bus.cmd_ready, 1'b1);

    // Combinational full_adder sweep, back-to-back
    k_fa = 1'b1;
    set_kernel(0, 0, '0);
    for (int v = 0; v < 8; v++) run_job(IN_W'(v), 0, $sformatf("fa%0d", v));
    check("fa/count8", job_count, 8);
    k_fa = 1'b0;

    // ap_ready at +1, ap_done at +4, result strobed with done
    set_kernel(1, 4, 16'h0010);
    run_job(3'b101, 0, "lat4");

    // Kernel that never completes -> timeout
    set_kernel(1, 1000, 16'h0000);
    run_job(3'b011, 0, "hang");

    // Done without any result strobe
    set_kernel(0, 2, 16'h0000);
    run_job(3'b110, 0, "novld");

    // Response back-pressure for 5 cycles
    set_kernel(0, 1, 16'h0002);
    run_job(3'b001, 5, "hold5");

    // Multiple strobes, last (same cycle as done) wins
    set_kernel(0, 3, 16'h000D);
    run_job(3'b010, 0, "lastwins");

    // Done on the expiry cycle completes normally; one later times out
    set_kernel(2, TMO - 1, 16'h0001);
    run_job(3'b100, 0, "done_at_expiry");
    set_kernel(TMO + 1, TMO, 16'h00FF);
    run_job(3'b111, 0, "done_after_expiry");

    // Randomized jobs with kernel noise outside the job window
    k_stray = 1'b1;
    for (int j = 0; j < 30; j++) begin
      int dl;
      dl = $urandom_range(0, 10);
      set_kernel($urandom_range(0, dl), dl,
                 ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      run_job(IN_W'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", j));
    end
    k_stray = 1'b0;

    // Reset pulsed while the sequencer sits in WAIT
    set_kernel(1, 4, 16'h0010);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 3'b101;
    wait_n = 0;
    while (bus.cmd_ready !== 1'b1 && wait_n < 20) begin
      @(negedge ap_clk);
      wait_n++;
    end
    check("rst_wait/accept_wait", wait_n, 0);
    @(negedge ap_clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge ap_clk);
    check("rst_wait/in_wait", {busy, bus.dut_ap_start, bus.rsp_valid}, 3'b100);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("rst_wait/ctrl", {busy, bus.dut_ap_start, bus.rsp_valid, bus.cmd_ready}, 4'b0000);
    check("rst_wait/count", job_count, 0);
    check("rst_wait/data", {bus.rsp_data, bus.rsp_status}, '0);
    ap_rst      = 1'b0;
    model_data  = '0;
    model_count = 0;
    @(negedge ap_clk);
    check("rst_wait/ready_rises", bus.cmd_ready, 1'b1);
    set_kernel(0, 0, 16'h0001);
    run_job(3'b001, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
